// File: rtl/alu_muldiv_if.sv
// Handshake bundle between decode (master) and the EX-stage execution unit (slave).
// The master also drives out_ready on behalf of the writeback/branch consumer.
interface alu_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             flag;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, res, flag, illegal
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, res, flag, illegal
  );
endinterface

// File: rtl/alu_muldiv.sv
// Handshaked integer ALU with registered result and an optional iterative mul/div engine.
// Define ALU_MULDIV_EN to build the engine; otherwise opcodes 16..23 report illegal.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic         cpu_clk,
  input logic         cpu_rst,
  alu_muldiv_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OpAdd = 5'd0, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu,
    OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu, OpMul, OpMulh, OpMulhsu, OpMulhu,
    OpDiv, OpDivu, OpRem, OpRemu
  } op_e;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic {StIdle, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             illegal_q, illegal_d;
  logic             accept;

  // Single-cycle ALU on the presented operands.
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;
  logic             lt_s, lt_u, eq;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag, alu_illegal;

  assign diff  = bus.a - bus.b;
  assign shamt = bus.b[SW-1:0];
  assign lt_s  = $signed(bus.a) < $signed(bus.b);
  assign lt_u  = bus.a < bus.b;
  assign eq    = bus.a == bus.b;

  always_comb begin
    alu_res     = '0;
    alu_flag    = 1'b0;
    alu_illegal = 1'b0;
    case (bus.op)
      OpAdd:   alu_res = bus.a + bus.b;
      OpSub:   alu_res = diff;
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpXor:   alu_res = bus.a ^ bus.b;
      OpSll:   alu_res = bus.a << shamt;
      OpSrl:   alu_res = bus.a >> shamt;
      OpSra:   alu_res = $unsigned($signed(bus.a) >>> shamt);
      OpSlt:   begin alu_res = {{(WIDTH-1){1'b0}}, lt_s}; alu_flag = lt_s; end
      OpSltu:  begin alu_res = {{(WIDTH-1){1'b0}}, lt_u}; alu_flag = lt_u; end
      OpBeq:   begin alu_res = diff; alu_flag = eq;    end
      OpBne:   begin alu_res = diff; alu_flag = ~eq;   end
      OpBlt:   begin alu_res = diff; alu_flag = lt_s;  end
      OpBge:   begin alu_res = diff; alu_flag = ~lt_s; end
      OpBltu:  begin alu_res = diff; alu_flag = lt_u;  end
      OpBgeu:  begin alu_res = diff; alu_flag = ~lt_u; end
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             is_md, is_div, a_neg, b_neg, div_special, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;
  logic [2:0]       md_op_q, md_op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   add_sum, rem_sh, rem_diff;

  assign is_md     = bus.op[4:3] == 2'b10;
  assign is_div    = is_md & bus.op[2];
  assign a_neg     = bus.a[WIDTH-1] & (bus.op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem});
  assign b_neg     = bus.b[WIDTH-1] & (bus.op inside {OpMul, OpMulh, OpDiv, OpRem});
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign last_iter = cnt_q == SW'(WIDTH - 1);

  // Divide-by-zero and signed overflow complete at accept without iterating.
  always_comb begin
    div_special = 1'b0;
    special_res = '0;
    if (is_div) begin
      if (bus.b == '0) begin
        div_special = 1'b1;
        special_res = bus.op[1] ? bus.a : '1;
      end else if (!bus.op[0] && bus.a == {1'b1, {(WIDTH-1){1'b0}}} && bus.b == '1) begin
        div_special = 1'b1;
        special_res = bus.op[1] ? '0 : bus.a;
      end
    end
  end

  // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (!md_op_q[2]) begin
      prod_step = {add_sum, prod_q[WIDTH-1:1]};
    end else if (rem_diff[WIDTH]) begin
      prod_step = {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end else begin
      prod_step = {rem_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end
  end

  function automatic logic [WIDTH-1:0] md_finish(logic [2*WIDTH-1:0] p, logic [2:0] mop,
                                                 logic neg);
    logic [2*WIDTH-1:0] ps;
    logic [WIDTH-1:0]   sel;
    if (mop[2]) begin
      sel = mop[1] ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
      return neg ? -sel : sel;
    end
    ps = neg ? -p : p;
    return (mop[1:0] == 2'b00) ? ps[WIDTH-1:0] : ps[2*WIDTH-1:WIDTH];
  endfunction
`endif

  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef ALU_MULDIV_EN
          state_d = (is_md & ~div_special) ? StBusy : StDone;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      StBusy: if (last_iter) state_d = StDone;
`endif
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle) & ~cpu_rst;
    bus.out_valid = state_q == StDone;
  end

  assign bus.res     = res_q;
  assign bus.flag    = flag_q;
  assign bus.illegal = illegal_q;

  always_comb begin
    res_d     = res_q;
    flag_d    = flag_q;
    illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
    md_op_d = md_op_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif
    if (accept) begin
      res_d     = alu_res;
      flag_d    = alu_flag;
      illegal_d = alu_illegal;
`ifdef ALU_MULDIV_EN
      if (is_md) begin
        res_d     = special_res;
        flag_d    = 1'b0;
        illegal_d = 1'b0;
        md_op_d   = bus.op[2:0];
        neg_d     = (is_div & bus.op[1]) ? a_neg : a_neg ^ b_neg;
        mcand_d   = is_div ? b_mag : a_mag;
        prod_d    = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
        cnt_d     = '0;
      end
`endif
    end
`ifdef ALU_MULDIV_EN
    else if (state_q == StBusy) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + 1'b1;
      if (last_iter) res_d = md_finish(prod_step, md_op_q, neg_q);
    end
`endif
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      res_q     <= '0;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      md_op_q   <= '0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      res_q     <= res_d;
      flag_q    <= flag_d;
      illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
      md_op_q   <= md_op_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand-written backpressure/reset/flush sequences.
module tb_alu_muldiv;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.cpu_clk(clk), .cpu_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         flag;
    logic         ill;
    int           cyc;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [4:0] op, input logic [W-1:0] a, b, res,
                              input logic flag, ill, input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flag = flag; v.ill = ill; v.cyc = cyc;
    tv.push_back(v);
  endfunction

  // Reference: cycles is the count from the accept edge to the first cycle out_valid is seen.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, b,
                                output logic [W-1:0] r, output logic f, output logic il,
                                output int cyc);
    longint       sa, sb, ua, ub;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r = '0; f = 1'b0; il = 1'b0; cyc = 1; p = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; r = p[31:0]; end
      5'd8:  begin f = sa < sb; r = {31'b0, f}; end
      5'd9:  begin f = ua < ub; r = {31'b0, f}; end
      5'd10: begin r = a - b; f = a == b; end
      5'd11: begin r = a - b; f = a != b; end
      5'd12: begin r = a - b; f = sa < sb; end
      5'd13: begin r = a - b; f = sa >= sb; end
      5'd14: begin r = a - b; f = ua < ub; end
      5'd15: begin r = a - b; f = ua >= ub; end
`ifdef ALU_MULDIV_EN
      5'd16: begin p = sa * sb; r = p[31:0];  cyc = 33; end
      5'd17: begin p = sa * sb; r = p[63:32]; cyc = 33; end
      5'd18: begin p = sa * ub; r = p[63:32]; cyc = 33; end
      5'd19: begin p = ua * ub; r = p[63:32]; cyc = 33; end
      5'd20: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == '1) r = a;
        else begin p = sa / sb; r = p[31:0]; cyc = 33; end
      end
      5'd21: begin
        if (b == 0) r = '1;
        else begin r = a / b; cyc = 33; end
      end
      5'd22: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == '1) r = '0;
        else begin p = sa % sb; r = p[31:0]; cyc = 33; end
      end
      5'd23: begin
        if (b == 0) r = a;
        else begin r = a % b; cyc = 33; end
      end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Called at posedge+1 with the unit idle; leaves the unit idle at posedge+1.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, b,
                        output logic [W-1:0] r, output logic f, output logic il,
                        output int cyc);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 5'($urandom); bus.a = $urandom; bus.b = $urandom;
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = bus.res; f = bus.flag; il = bus.illegal;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic apply(input string name, input logic [4:0] op, input logic [W-1:0] a, b,
                       input logic [W-1:0] er, input logic ef, input logic eil, input int ecyc);
    logic [W-1:0] r;
    logic         f, il;
    int           cyc;
    run_op(op, a, b, r, f, il, cyc);
    check({name, " res"}, r, er);
    check({name, " flag"}, f, ef);
    check({name, " illegal"}, il, eil);
    check({name, " latency"}, cyc, ecyc);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] s[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return s[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [W-1:0] er, a, b;
    logic         ef, eil;
    logic [4:0]   op;
    int           ecyc, seen;

    rst = 1'b1; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset res", bus.res, 0);
    check("reset flag", bus.flag, 0);
    check("reset illegal", bus.illegal, 0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    add(5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 1);
    add(5'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 0, 0, 1);
    add(5'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 1);
    add(5'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 1);
    add(5'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0, 0, 1);
    add(5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 0, 0, 1);
    add(5'd5,  32'h1,         32'h3F,        32'h8000_0000, 0, 0, 1);
    add(5'd6,  32'h8000_0000, 32'h1F,        32'h1,         0, 0, 1);
    add(5'd8,  32'hFFFF_FFFF, 32'h1,         32'h1,         1, 0, 1);
    add(5'd9,  32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0, 1);
    add(5'd12, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 1, 0, 1);
    add(5'd14, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 0, 0, 1);
    add(5'd10, 32'h5,         32'h5,         32'h0,         1, 0, 1);
    add(5'd11, 32'h5,         32'h5,         32'h0,         0, 0, 1);
    add(5'd13, 32'h8000_0000, 32'h0,         32'h8000_0000, 0, 0, 1);
    add(5'd15, 32'h8000_0000, 32'h0,         32'h8000_0000, 1, 0, 1);
    add(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         0, 0, 33);
    add(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 33);
    add(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0, 0, 33);
    add(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33);
    add(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1);
    add(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 0, 1);
    add(5'd21, 32'h7,         32'h0,         32'hFFFF_FFFF, 0, 0, 1);
    add(5'd23, 32'h7,         32'h0,         32'h7,         0, 0, 1);
    add(5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 0, 0, 33);
    add(5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 0, 0, 33);
    add(5'd21, 32'd100,       32'd7,         32'd14,        0, 0, 33);
    add(5'd23, 32'd100,       32'd7,         32'd2,         0, 0, 33);
    add(5'd24, 32'h1234,      32'h5678,      32'h0,         0, 1, 1);
    add(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0, 1, 1);

    foreach (tv[i]) begin
`ifndef ALU_MULDIV_EN
      if (tv[i].op inside {[5'd16:5'd23]}) begin
        tv[i].res = '0; tv[i].flag = 1'b0; tv[i].ill = 1'b1; tv[i].cyc = 1;
      end
`endif
      apply($sformatf("vec%0d op%0d", i, tv[i].op), tv[i].op, tv[i].a, tv[i].b,
            tv[i].res, tv[i].flag, tv[i].ill, tv[i].cyc);
    end

    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = pick();
      b  = pick();
      model(op, a, b, er, ef, eil, ecyc);
      apply($sformatf("rand%0d op%0d a%0h b%0h", i, op, a, b), op, a, b, er, ef, eil, ecyc);
    end

    // Backpressure: result must hold while out_ready stays low.
    bus.in_valid = 1'b1; bus.op = 5'd0; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d res", i), bus.res, 32'd7);
      check($sformatf("stall%0d out_valid", i), bus.out_valid, 1);
      check($sformatf("stall%0d in_ready", i), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("stall release out_valid", bus.out_valid, 0);
    check("stall release in_ready", bus.in_ready, 1);

    // flush together with out_ready in DONE.
    bus.in_valid = 1'b1; bus.op = 5'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("flush+ready out_valid", bus.out_valid, 0);
    check("flush+ready in_ready", bus.in_ready, 1);

    // flush together with in_valid in IDLE: nothing accepted.
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = 5'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    seen = 0;
    repeat (3) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush+valid no accept", seen, 0);

    // Reset pulse mid-operation (BUSY with the engine, DONE without).
`ifdef ALU_MULDIV_EN
    bus.in_valid = 1'b1; bus.op = 5'd16; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
`else
    bus.in_valid = 1'b1; bus.op = 5'd0; bus.a = 32'h1; bus.b = 32'h1;
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst mid-op out_valid", bus.out_valid, 0);
    check("rst mid-op in_ready", bus.in_ready, 0);
    check("rst mid-op res", bus.res, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst mid-op no result", seen, 0);

    // flush mid-operation.
`ifdef ALU_MULDIV_EN
    bus.in_valid = 1'b1; bus.op = 5'd21; bus.a = 32'd1000; bus.b = 32'd3;
`else
    bus.in_valid = 1'b1; bus.op = 5'd1; bus.a = 32'd9; bus.b = 32'd3;
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush mid-op out_valid", bus.out_valid, 0);
    check("flush mid-op in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (40) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush mid-op no result", seen, 0);

    model(5'd1, 32'd10, 32'd3, er, ef, eil, ecyc);
    apply("recovery sub", 5'd1, 32'd10, 32'd3, er, ef, eil, ecyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
